// File: rtl/mnist_accel_pkg.sv
// rtl/mnist_accel_pkg.sv - address map, sizes, state enums and decoder for the MNIST accelerator slave
package mnist_accel_pkg;

    localparam logic [31:0] BASE_ADDR   = 32'h3100_0000;
    localparam logic [31:0] OFS_CTRL    = 32'h0000_0000;
    localparam logic [31:0] OFS_STATUS  = 32'h0100_0000;
    localparam logic [31:0] OFS_RESULTS = 32'h0200_0000;
    localparam logic [31:0] OFS_IMAGE   = 32'h0300_0000;
    localparam int          IMG_WORDS   = 785;
    localparam int          NUM_CLASSES = 10;
    localparam int          CLASS_WORD  = 10;
    localparam logic [31:0] ERR_DATA    = 32'hDEAD_BEEF;

    typedef enum logic {W_IDLE, W_RESP} wr_state_e;
    typedef enum logic {R_IDLE, R_DATA} rd_state_e;
    typedef enum logic [1:0] {A_IDLE, A_SCAN, A_DONE} am_state_e;

    typedef enum logic [2:0] {
        RG_CTRL, RG_STATUS, RG_RESULT, RG_CLASS, RG_IMAGE, RG_NONE
    } reg_sel_e;

    typedef struct packed {
        reg_sel_e    sel;
        logic [9:0]  idx;
    } reg_dec_t;

    // Each register block occupies one 16 MB region; bits [1:0] never matter.
    function automatic reg_dec_t decode(input logic [31:0] addr);
        reg_dec_t    d;
        logic [7:0]  region;
        logic [21:0] wofs;
        d.sel  = RG_NONE;
        d.idx  = '0;
        region = addr[31:24] - BASE_ADDR[31:24];
        wofs   = addr[23:2];
        if (region == OFS_CTRL[31:24]) begin
            if (wofs == '0) d.sel = RG_CTRL;
        end else if (region == OFS_STATUS[31:24]) begin
            if (wofs == '0) d.sel = RG_STATUS;
        end else if (region == OFS_RESULTS[31:24]) begin
            if (32'(wofs) < 32'(NUM_CLASSES)) begin
                d.sel = RG_RESULT;
                d.idx = wofs[9:0];
            end else if (32'(wofs) == 32'(CLASS_WORD)) begin
                d.sel = RG_CLASS;
            end
        end else if (region == OFS_IMAGE[31:24]) begin
            if (32'(wofs) < 32'(IMG_WORDS)) begin
                d.sel = RG_IMAGE;
                d.idx = wofs[9:0];
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/mnist_accel_axi_slave_if.sv
// rtl/mnist_accel_axi_slave_if.sv - AXI4-lite-style bus between picorv32 and the accelerator slave
interface mnist_accel_axi_slave_if;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_awaddr;
    logic        s_wvalid;
    logic        s_wready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_bvalid;
    logic        s_bready;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_araddr;
    logic        s_rvalid;
    logic        s_rready;
    logic [31:0] s_rdata;

    modport slave (
        input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
               s_arvalid, s_araddr, s_rready,
        output s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rdata
    );

    modport master (
        output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
               s_arvalid, s_araddr, s_rready,
        input  s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rdata
    );
endinterface

// File: rtl/mnist_argmax.sv
// rtl/mnist_argmax.sv - sequential signed argmax over the captured class scores
module mnist_argmax
    import mnist_accel_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        abort,
    input  logic [NUM_CLASSES*32-1:0]   results,
    output logic                        busy,
    output logic [3:0]                  class_id,
    output logic                        valid
);

    localparam logic [3:0] LAST = 4'(NUM_CLASSES - 1);

    am_state_e                  state, state_nx;
    logic [NUM_CLASSES*32-1:0]  snap;
    logic [3:0]                 k;
    logic [3:0]                 best_idx;
    logic signed [31:0]         best;
    logic signed [31:0]         cur;
    logic                       take;

    // Strict '>' keeps the earliest index on ties.
    always_comb begin
        cur      = snap[{k, 5'd0} +: 32];
        take     = (k == 4'd0) || (cur > best);
        state_nx = state;
        case (state)
            A_IDLE:  if (start) state_nx = A_SCAN;
            A_SCAN:  if (k == LAST) state_nx = A_DONE;
            A_DONE:  state_nx = A_IDLE;
            default: state_nx = A_IDLE;
        endcase
        if (abort) state_nx = A_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= A_IDLE;
            snap     <= '0;
            k        <= '0;
            best     <= '0;
            best_idx <= '0;
            class_id <= '0;
            valid    <= 1'b0;
        end else begin
            state <= state_nx;
            if (abort) begin
                valid <= 1'b0;
            end else begin
                case (state)
                    A_IDLE: if (start) begin
                        snap  <= results;
                        k     <= '0;
                        valid <= 1'b0;
                    end
                    A_SCAN: begin
                        if (take) begin
                            best     <= cur;
                            best_idx <= k;
                        end
                        k <= k + 4'd1;
                        if (k == LAST) begin
                            class_id <= take ? k : best_idx;
                            valid    <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy = (state == A_SCAN);

endmodule

// File: rtl/mnist_accel_axi_slave.sv
// rtl/mnist_accel_axi_slave.sv - register/image-buffer slave fronting the MNIST accelerator core
module mnist_accel_axi_slave
    import mnist_accel_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    mnist_accel_axi_slave_if.slave      axi,
    output logic                        accel_reset,
    output logic [IMG_WORDS*32-1:0]     in_image,
    input  logic                        accel_ready,
    input  logic [NUM_CLASSES*32-1:0]   results,
    output logic                        addr_err
);

    wr_state_e   wstate, wstate_nx;
    rd_state_e   rstate, rstate_nx;

    logic        aw_full, w_full;
    logic [31:0] aw_addr_q, w_data_q;
    logic [3:0]  w_strb_q;
    logic        aw_hs, w_hs, ar_hs, wr_commit;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_strb;
    reg_dec_t    wr_dec, rd_dec;
    logic [31:0] rd_word;

    logic        ready_q, ready_q2;
    logic        am_start, am_abort, am_busy, class_valid;
    logic [3:0]  class_id;

    logic [31:0] img_mem [IMG_WORDS];

    assign axi.s_awready = !aw_full && (wstate == W_IDLE);
    assign axi.s_wready  = !w_full  && (wstate == W_IDLE);
    assign axi.s_bvalid  = (wstate == W_RESP);
    assign axi.s_arready = (rstate == R_IDLE);
    assign axi.s_rvalid  = (rstate == R_DATA);

    assign aw_hs = axi.s_awvalid && axi.s_awready;
    assign w_hs  = axi.s_wvalid  && axi.s_wready;
    assign ar_hs = axi.s_arvalid && axi.s_arready;

    // The last beat to arrive commits on its own handshake edge, using the live bus value.
    assign wr_commit = (aw_full || aw_hs) && (w_full || w_hs) && (wstate == W_IDLE);
    assign wr_addr   = aw_full ? aw_addr_q : axi.s_awaddr;
    assign wr_data   = w_full  ? w_data_q  : axi.s_wdata;
    assign wr_strb   = w_full  ? w_strb_q  : axi.s_wstrb;
    assign wr_dec    = decode(wr_addr);
    assign rd_dec    = decode(axi.s_araddr);

    assign am_start = ready_q && !ready_q2;
    assign am_abort = wr_commit && (wr_dec.sel == RG_CTRL);

    always_comb begin
        wstate_nx = wstate;
        case (wstate)
            W_IDLE:  if (wr_commit) wstate_nx = W_RESP;
            W_RESP:  if (axi.s_bready) wstate_nx = W_IDLE;
            default: wstate_nx = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_nx = rstate;
        case (rstate)
            R_IDLE:  if (axi.s_arvalid) rstate_nx = R_DATA;
            R_DATA:  if (axi.s_rready) rstate_nx = R_IDLE;
            default: rstate_nx = R_IDLE;
        endcase
    end

    always_comb begin
        rd_word = ERR_DATA;
        case (rd_dec.sel)
            RG_CTRL:   rd_word = {31'b0, accel_reset};
            RG_STATUS: rd_word = {29'b0, am_busy, class_valid, accel_ready};
            RG_RESULT: rd_word = results[{rd_dec.idx[3:0], 5'd0} +: 32];
            RG_CLASS:  rd_word = {28'b0, class_id};
            RG_IMAGE:  rd_word = img_mem[rd_dec.idx];
            default:   rd_word = ERR_DATA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wstate      <= W_IDLE;
            rstate      <= R_IDLE;
            aw_full     <= 1'b0;
            w_full      <= 1'b0;
            aw_addr_q   <= '0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            axi.s_rdata <= '0;
            accel_reset <= 1'b1;
            addr_err    <= 1'b0;
            ready_q     <= 1'b0;
            ready_q2    <= 1'b0;
        end else begin
            wstate   <= wstate_nx;
            rstate   <= rstate_nx;
            ready_q  <= accel_ready;
            ready_q2 <= ready_q;
            if (wr_commit) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
            end else begin
                if (aw_hs) begin
                    aw_full   <= 1'b1;
                    aw_addr_q <= axi.s_awaddr;
                end
                if (w_hs) begin
                    w_full   <= 1'b1;
                    w_data_q <= axi.s_wdata;
                    w_strb_q <= axi.s_wstrb;
                end
            end
            if (am_abort && wr_strb[0]) accel_reset <= wr_data[0];
            if (ar_hs) axi.s_rdata <= rd_word;
            addr_err <= (wr_commit && (wr_dec.sel == RG_NONE)) ||
                        (ar_hs && (rd_dec.sel == RG_NONE));
        end
    end

    // Image buffer is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!reset && wr_commit && (wr_dec.sel == RG_IMAGE)) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) img_mem[wr_dec.idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    for (genvar j = 0; j < IMG_WORDS; j++) begin : g_img
        assign in_image[32*j +: 32] = img_mem[j];
    end

    mnist_argmax u_argmax (
        .clk      (clk),
        .reset    (reset),
        .start    (am_start),
        .abort    (am_abort),
        .results  (results),
        .busy     (am_busy),
        .class_id (class_id),
        .valid    (class_valid)
    );

endmodule

// File: tb/tb_mnist_accel_axi_slave.sv
// tb/tb_mnist_accel_axi_slave.sv - directed self-checking bench for mnist_accel_axi_slave
module tb_mnist_accel_axi_slave;
    import mnist_accel_pkg::*;

    localparam logic [31:0] A_CTRL   = 32'h3100_0000;
    localparam logic [31:0] A_STATUS = 32'h3200_0000;
    localparam logic [31:0] A_RES    = 32'h3300_0000;
    localparam logic [31:0] A_CLASS  = 32'h3300_0028;
    localparam logic [31:0] A_IMG    = 32'h3400_0000;

    logic                       clk = 1'b0;
    logic                       reset = 1'b1;
    logic                       accel_reset;
    logic [IMG_WORDS*32-1:0]    in_image;
    logic                       accel_ready = 1'b0;
    logic [NUM_CLASSES*32-1:0]  results = '0;
    logic                       addr_err;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          rv [10];
    int          busy_cnt;
    logic [31:0] rd;
    logic        er;

    always #5 clk = ~clk;

    mnist_accel_axi_slave_if axi ();

    mnist_accel_axi_slave dut (
        .clk         (clk),
        .reset       (reset),
        .axi         (axi),
        .accel_reset (accel_reset),
        .in_image    (in_image),
        .accel_ready (accel_ready),
        .results     (results),
        .addr_err    (addr_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_results();
        for (int k = 0; k < 10; k++) results[32*k +: 32] = rv[k];
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic err);
        bit aw_ok = 0;
        bit w_ok = 0;
        int n = 0;
        @(negedge clk);
        axi.s_awaddr = a; axi.s_awvalid = 1'b1;
        axi.s_wdata = d; axi.s_wstrb = s; axi.s_wvalid = 1'b1;
        while (!(aw_ok && w_ok) && n < 20) begin
            if (axi.s_awvalid && axi.s_awready) aw_ok = 1;
            if (axi.s_wvalid && axi.s_wready) w_ok = 1;
            @(negedge clk);
            n++;
            if (aw_ok) axi.s_awvalid = 1'b0;
            if (w_ok) axi.s_wvalid = 1'b0;
        end
        n = 0;
        while (!axi.s_bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("write bvalid", axi.s_bvalid, 1);
        err = addr_err;
        axi.s_bready = 1'b1;
        @(negedge clk);
        axi.s_bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic err);
        int n = 0;
        @(negedge clk);
        axi.s_araddr = a; axi.s_arvalid = 1'b1;
        while (!axi.s_arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        axi.s_arvalid = 1'b0;
        check("read rvalid", axi.s_rvalid, 1);
        d = axi.s_rdata;
        err = addr_err;
        axi.s_rready = 1'b1;
        @(negedge clk);
        axi.s_rready = 1'b0;
    endtask

    initial begin
        axi.s_awvalid = 0; axi.s_awaddr = '0; axi.s_wvalid = 0; axi.s_wdata = '0;
        axi.s_wstrb = '0; axi.s_bready = 0; axi.s_arvalid = 0; axi.s_araddr = '0;
        axi.s_rready = 0;

        // 1. reset state and basic register reads
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst awready", axi.s_awready, 1);
        check("rst wready", axi.s_wready, 1);
        check("rst arready", axi.s_arready, 1);
        check("rst bvalid", axi.s_bvalid, 0);
        check("rst rvalid", axi.s_rvalid, 0);
        check("rst rdata", axi.s_rdata, 0);
        check("rst accel_reset", accel_reset, 1);
        check("rst addr_err", addr_err, 0);
        do_read(A_STATUS, rd, er);
        check("status after reset", rd, 32'h0);
        check("status addr_err", er, 0);
        do_read(A_CTRL, rd, er);
        check("ctrl after reset", rd, 32'h1);
        do_write(A_CTRL, 32'h0, 4'hF, er);
        check("accel_reset released", accel_reset, 0);
        do_read(A_CTRL, rd, er);
        check("ctrl after write", rd, 32'h0);

        // 2. split AW/W timing and byte strobes on image word 784
        do_write(A_IMG + 32'hC40, 32'hAABB_CCDD, 4'hF, er);
        @(negedge clk);
        axi.s_awaddr = A_IMG + 32'hC40; axi.s_awvalid = 1'b1;
        @(negedge clk);
        axi.s_awvalid = 1'b0;
        check("aw held awready", axi.s_awready, 0);
        check("split bvalid c1", axi.s_bvalid, 0);
        @(negedge clk);
        check("split bvalid c2", axi.s_bvalid, 0);
        @(negedge clk);
        check("split bvalid c3", axi.s_bvalid, 0);
        axi.s_wdata = 32'h1234_5678; axi.s_wstrb = 4'b0011; axi.s_wvalid = 1'b1;
        @(negedge clk);
        axi.s_wvalid = 1'b0;
        check("split bvalid c4", axi.s_bvalid, 1);
        axi.s_bready = 1'b1;
        @(negedge clk);
        axi.s_bready = 1'b0;
        check("bvalid after bready", axi.s_bvalid, 0);
        do_read(A_IMG + 32'hC40, rd, er);
        check("img784 strobed", rd, 32'hAABB_5678);
        check("in_image word 784", in_image[25119:25088], 32'hAABB_5678);

        // 3. argmax with a tie, accel_ready dropping mid-scan
        rv = '{-5, 7, 7, 3, 0, 1, 2, -1, 6, 4};
        load_results();
        @(negedge clk);
        accel_ready = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 2) accel_ready = 1'b0;
            busy_cnt += int'(dut.u_argmax.busy);
        end
        check("busy cycles", busy_cnt, 10);
        check("class_valid after scan", dut.u_argmax.valid, 1);
        do_read(A_CLASS, rd, er);
        check("class tie", rd, 32'd1);
        do_read(A_STATUS, rd, er);
        check("status done", rd, 32'h2);
        do_read(A_RES + 32'h8, rd, er);
        check("result 2", rd, 32'd7);
        do_read(A_RES, rd, er);
        check("result 0", rd, 32'hFFFF_FFFB);

        rv = '{-2147483647 - 1, -1, -1, -1, -1, -1, -1, -1, -1, 1};
        load_results();
        @(negedge clk);
        accel_ready = 1'b1;
        repeat (14) @(negedge clk);
        accel_ready = 1'b0;
        do_read(A_CLASS, rd, er);
        check("class signed", rd, 32'd9);
        do_write(A_CTRL, 32'h0, 4'hF, er);
        do_read(A_STATUS, rd, er);
        check("ctrl write clears valid", rd, 32'h0);

        // 4. unmapped accesses
        do_read(32'h3500_0000, rd, er);
        check("unmapped rdata", rd, ERR_DATA);
        check("unmapped read addr_err", er, 1);
        check("addr_err one cycle", addr_err, 0);
        do_write(A_IMG + 32'hC44, 32'h5555_5555, 4'hF, er);
        check("unmapped write addr_err", er, 1);
        do_read(A_IMG + 32'hC40, rd, er);
        check("img784 untouched", rd, 32'hAABB_5678);
        do_write(A_RES, 32'h1, 4'hF, er);
        check("RO write no addr_err", er, 0);

        // 5. stalled R and B channels
        @(negedge clk);
        axi.s_araddr = A_RES + 32'h24; axi.s_arvalid = 1'b1;
        @(negedge clk);
        axi.s_arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall rvalid", axi.s_rvalid, 1);
            check("stall rdata", axi.s_rdata, 32'd1);
            check("stall arready", axi.s_arready, 0);
            @(negedge clk);
        end
        axi.s_rready = 1'b1;
        @(negedge clk);
        axi.s_rready = 1'b0;
        check("rvalid released", axi.s_rvalid, 0);
        check("arready released", axi.s_arready, 1);

        axi.s_awaddr = A_IMG + 32'h14; axi.s_awvalid = 1'b1;
        axi.s_wdata = 32'h11; axi.s_wstrb = 4'hF; axi.s_wvalid = 1'b1;
        @(negedge clk);
        axi.s_awvalid = 1'b0; axi.s_wvalid = 1'b0;
        check("stall b first", axi.s_bvalid, 1);
        axi.s_awaddr = A_IMG + 32'h18; axi.s_awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("stall bvalid", axi.s_bvalid, 1);
            check("stall awready", axi.s_awready, 0);
            @(negedge clk);
        end
        axi.s_bready = 1'b1;
        @(negedge clk);
        axi.s_bready = 1'b0;
        check("bvalid released", axi.s_bvalid, 0);
        check("awready released", axi.s_awready, 1);
        axi.s_wdata = 32'h22; axi.s_wvalid = 1'b1;
        @(negedge clk);
        axi.s_awvalid = 1'b0; axi.s_wvalid = 1'b0;
        check("second write bvalid", axi.s_bvalid, 1);
        axi.s_bready = 1'b1;
        @(negedge clk);
        axi.s_bready = 1'b0;
        do_read(A_IMG + 32'h14, rd, er);
        check("img5", rd, 32'h11);
        do_read(A_IMG + 32'h18, rd, er);
        check("img6", rd, 32'h22);

        // 6. reset during a scan with an address beat latched
        @(negedge clk);
        accel_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("busy before reset", dut.u_argmax.busy, 1);
        axi.s_awaddr = A_CTRL; axi.s_awvalid = 1'b1;
        @(negedge clk);
        axi.s_awvalid = 1'b0;
        accel_ready = 1'b0;
        check("aw latched before reset", axi.s_awready, 0);
        reset = 1'b1;
        @(negedge clk);
        check("reset accel_reset", accel_reset, 1);
        check("reset bvalid", axi.s_bvalid, 0);
        check("reset busy", dut.u_argmax.busy, 0);
        check("reset class_valid", dut.u_argmax.valid, 0);
        check("reset awready", axi.s_awready, 1);
        reset = 1'b0;
        axi.s_wdata = 32'h0; axi.s_wstrb = 4'hF; axi.s_wvalid = 1'b1;
        @(negedge clk);
        axi.s_wvalid = 1'b0;
        repeat (2) @(negedge clk);
        check("dropped aw no bvalid", axi.s_bvalid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
